// File: rtl/cnn_layer_accel_octo_datain_feeder_if.sv
// Stream bundle of the octo datain feeder: sequencer and pixel inputs plus the tagged output word.
// The master modport is the feeder itself; the slave modport is its surrounding environment.
interface cnn_layer_accel_octo_datain_feeder_if #(
  parameter int C_DATA_WIDTH = 16
);
  logic                    seq_in_valid;
  logic [C_DATA_WIDTH-1:0] seq_in_data;
  logic                    seq_in_rdy;
  logic                    pix_in_valid;
  logic [C_DATA_WIDTH-1:0] pix_in_data;
  logic                    pix_in_rdy;
  logic                    datain_valid;
  logic [C_DATA_WIDTH-1:0] datain;
  logic                    seq_datain_tag;
  logic                    pixel_datain_tag;
  logic                    seq_datain_rdy;
  logic                    pixel_datain_rdy;

  modport master (
    input  seq_in_valid, seq_in_data, pix_in_valid, pix_in_data,
    input  seq_datain_rdy, pixel_datain_rdy,
    output seq_in_rdy, pix_in_rdy,
    output datain_valid, datain, seq_datain_tag, pixel_datain_tag
  );

  modport slave (
    output seq_in_valid, seq_in_data, pix_in_valid, pix_in_data,
    output seq_datain_rdy, pixel_datain_rdy,
    input  seq_in_rdy, pix_in_rdy,
    input  datain_valid, datain, seq_datain_tag, pixel_datain_tag
  );
endinterface

// File: rtl/cnn_layer_accel_octo_datain_feeder.sv
// Octo datain feeder: per map, streams num_seq sequencer words followed by
// (numRows+1)*(numCols+1) pixels through a single tagged output register.
module cnn_layer_accel_octo_datain_feeder #(
  parameter int C_BRAM_DEPTH = 1024,
  parameter int C_DATA_WIDTH = 16,
  localparam int L = $clog2(C_BRAM_DEPTH),
  localparam int S = $clog2((C_BRAM_DEPTH / 2) * 5)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [S:0]                           cfg_num_seq,
  input  logic [L-2:0]                         cfg_numRows,
  input  logic [L-2:0]                         cfg_numCols,
  cnn_layer_accel_octo_datain_feeder_if.master bus,
  output logic                                 new_map,
  output logic                                 busy,
  output logic                                 done
);

  localparam logic [S:0]   SEQ_ONE = 1;
  localparam logic [L-2:0] PIX_ONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEW_MAP,
    ST_SEND_SEQ,
    ST_SEND_PIX,
    ST_DONE
  } state_t;

  state_t              state;
  logic [S:0]          num_seq;
  logic [L-2:0]        num_rows;
  logic [L-2:0]        num_cols;
  logic [S:0]          seq_sent;
  logic [S:0]          seq_acc;
  logic [L-2:0]        row;
  logic [L-2:0]        col;
  logic [L-2:0]        acc_row;
  logic [L-2:0]        acc_col;
  logic                last_loaded;
  logic                xfer;
  logic                out_free;
  logic                seq_accept;
  logic                pix_accept;
  logic [C_DATA_WIDTH-1:0] word_in;

  assign xfer = bus.datain_valid &&
                ((bus.seq_datain_tag && bus.seq_datain_rdy) ||
                 (bus.pixel_datain_tag && bus.pixel_datain_rdy));
  assign out_free = !bus.datain_valid || xfer;

  // last_loaded gates off upstream once the final word of a class sits in the output register
  assign bus.seq_in_rdy = (state == ST_SEND_SEQ) && !last_loaded && out_free;
  assign bus.pix_in_rdy = (state == ST_SEND_PIX) && !last_loaded && out_free;
  assign seq_accept     = bus.seq_in_valid && bus.seq_in_rdy;
  assign pix_accept     = bus.pix_in_valid && bus.pix_in_rdy;
  assign word_in        = seq_accept ? bus.seq_in_data : bus.pix_in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= ST_IDLE;
      num_seq              <= '0;
      num_rows             <= '0;
      num_cols             <= '0;
      seq_sent             <= '0;
      seq_acc              <= '0;
      row                  <= '0;
      col                  <= '0;
      acc_row              <= '0;
      acc_col              <= '0;
      last_loaded          <= 1'b0;
      new_map              <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      bus.datain_valid     <= 1'b0;
      bus.datain           <= '0;
      bus.seq_datain_tag   <= 1'b0;
      bus.pixel_datain_tag <= 1'b0;
    end else begin
      new_map <= 1'b0;
      done    <= 1'b0;

      if (seq_accept || pix_accept) begin
        bus.datain_valid     <= 1'b1;
        bus.datain           <= word_in;
        bus.seq_datain_tag   <= seq_accept;
        bus.pixel_datain_tag <= pix_accept;
      end else if (xfer) begin
        bus.datain_valid     <= 1'b0;
        bus.seq_datain_tag   <= 1'b0;
        bus.pixel_datain_tag <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            num_seq     <= cfg_num_seq;
            num_rows    <= cfg_numRows;
            num_cols    <= cfg_numCols;
            seq_sent    <= '0;
            seq_acc     <= '0;
            row         <= '0;
            col         <= '0;
            acc_row     <= '0;
            acc_col     <= '0;
            last_loaded <= 1'b0;
            new_map     <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_NEW_MAP;
          end
        end

        ST_NEW_MAP: begin
          state <= (num_seq == '0) ? ST_SEND_PIX : ST_SEND_SEQ;
        end

        ST_SEND_SEQ: begin
          if (seq_accept) begin
            seq_acc <= seq_acc + SEQ_ONE;
            if (seq_acc + SEQ_ONE == num_seq) last_loaded <= 1'b1;
          end
          if (xfer) begin
            seq_sent <= seq_sent + SEQ_ONE;
            if (seq_sent + SEQ_ONE == num_seq) begin
              last_loaded <= 1'b0;
              state       <= ST_SEND_PIX;
            end
          end
        end

        // Accept-side and transfer-side raster positions run separately, one word apart at most
        ST_SEND_PIX: begin
          if (pix_accept) begin
            if (acc_col == num_cols) begin
              acc_col <= '0;
              acc_row <= acc_row + PIX_ONE;
            end else begin
              acc_col <= acc_col + PIX_ONE;
            end
            if (acc_row == num_rows && acc_col == num_cols) last_loaded <= 1'b1;
          end
          if (xfer) begin
            if (col == num_cols) begin
              col <= '0;
              row <= row + PIX_ONE;
            end else begin
              col <= col + PIX_ONE;
            end
            if (row == num_rows && col == num_cols) begin
              last_loaded <= 1'b0;
              done        <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cnn_layer_accel_octo_datain_feeder.md
CNN_LAYER_ACCEL_OCTO_DATAIN_FEEDER -- requirements
Module: cnn_layer_accel_octo_datain_feeder

Interface
REQ-001 The block SHALL have the parameter C_BRAM_DEPTH, default 1024, giving the per-row buffer depth; it sets L = clog2(C_BRAM_DEPTH) and S = clog2((C_BRAM_DEPTH/2)*5).
REQ-002 The block SHALL have the parameter C_DATA_WIDTH, default 16, giving the width of a pixel or sequencer word.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the ports are clk and rst.
REQ-004 Port list, as name  direction  width  meaning:
- clk  in  1  clock
- rst  in  1  async active-low reset
- start  in  1  begin map (pulse)
- cfg_num_seq  in  S+1  count of sequencer words
- cfg_numRows  in  L-1  last row index
- cfg_numCols  in  L-1  last column index
- seq_in_valid / seq_in_data / seq_in_rdy  in / in / out  1 / C_DATA_WIDTH / 1  upstream sequencer stream
- pix_in_valid / pix_in_data / pix_in_rdy  in / in / out  1 / C_DATA_WIDTH / 1  upstream pixel stream
- new_map  out  1  one-cycle pulse to the consumer
- datain_valid  out  1  output word valid
- datain  out  C_DATA_WIDTH  output word
- seq_datain_tag / pixel_datain_tag  out  1 each  output word class, one-hot while valid
- seq_datain_rdy / pixel_datain_rdy  in  1 each  consumer accept
- busy  out  1  map in progress
- done  out  1  one-cycle pulse, map complete

Function
REQ-005 An output transfer SHALL occur on a rising clk edge where datain_valid=1, the tag is 1, and the matching rdy is 1; a rdy whose tag is not the current tag SHALL be ignored.
REQ-006 While datain_valid=1 and no transfer occurs, datain and both tags SHALL hold stable.
REQ-007 The block SHALL use a single output register; an upstream word is accepted when in_valid && in_rdy.
- Upstream in_rdy for the active class SHALL equal (!datain_valid || transfer), combinationally.
- Upstream in_rdy for the other class SHALL be 0.
REQ-008 Throughput SHALL be one word per clk when upstream is valid and the consumer rdy is held high; upstream accept to datain_valid latency SHALL be 1 cycle.
REQ-009 The FSM SHALL have the states ST_IDLE, ST_NEW_MAP, ST_SEND_SEQ, ST_SEND_PIX and ST_DONE, with these transitions:
- ST_IDLE -> ST_NEW_MAP on start. The cfg_* values are latched at this edge; start in any other state SHALL be ignored.
- ST_NEW_MAP: new_map=1 for exactly this cycle; next state is ST_SEND_SEQ, or ST_SEND_PIX when the latched num_seq = 0.
- ST_SEND_SEQ: seq_datain_tag=1 on every valid word; go to ST_SEND_PIX in the cycle after the transfer that makes seq_sent = num_seq.
- ST_SEND_PIX: pixel_datain_tag=1; go to ST_DONE after the transfer with row = numRows and col = numCols.
- ST_DONE: done=1 for one cycle, then ST_IDLE.
REQ-010 The pixel counters SHALL behave as follows on each pixel transfer:
- col increments; when col = numCols it wraps to 0 and row increments.
- Both counters are L-1 bits.
- Total pixels per map = (numRows+1)*(numCols+1).
REQ-011 seq_sent SHALL be S+1 bits and SHALL clear on entry to ST_NEW_MAP.
REQ-012 Upstream accepts SHALL stop once the last word of a class has been accepted into the output register; no word of the next class may enter until that last word has transferred.
REQ-013 busy SHALL be 1 in every state except ST_IDLE.
REQ-014 A count of cfg_numCols = 0 SHALL mean a single column, and cfg_numRows = 0 a single row; no underflow is permitted.
REQ-015 A rdy asserted while datain_valid = 0 SHALL have no effect.

Reset
REQ-016 While rst = 0, the block SHALL asynchronously force the following, and SHALL release them on the first clk edge after rst = 1:
- state = ST_IDLE
- datain_valid, both tags, new_map, done, busy, seq_in_rdy, pix_in_rdy = 0
- datain, row, col, seq_sent and the latched cfg = 0
REQ-017 A reset asserted mid-map SHALL drop the in-flight output word; after release the block SHALL wait for a new start.

Verification
REQ-018 num_seq=5, numRows=2, numCols=3, upstream always valid, consumer rdy held high -> new_map pulse; 5 seq-tagged words back to back; 12 pixel-tagged words back to back; done 1 cycle after the final transfer; busy high throughout.
REQ-019 Consumer rdy toggled 1,0,1,0 during pixels -> every word is delivered exactly once, in order; datain is stable across the stall cycles; pix_in_rdy = 0 while stalled.
REQ-020 num_seq=0, numRows=0, numCols=0 -> ST_NEW_MAP goes directly to ST_SEND_PIX; exactly 1 pixel is sent, then done.
REQ-021 pixel_datain_rdy driven high during ST_SEND_SEQ -> no transfer; seq words continue only on seq_datain_rdy.
REQ-022 rst driven low while the 7th pixel of the REQ-018 map is valid -> all outputs are 0 immediately; a fresh start replays the map from seq word 0 with counters at 0.
REQ-023 start pulsed during ST_SEND_PIX -> ignored; cfg changes mid-map do not alter the pixel count.
